prbs_checker: RTL and testbench

//  Serial PRBS checker downstream of the 16-bit XNOR LFSR generator. Consumes the

---
 rtl/prbs_checker.sv | 172 +++++++++++++++++
 tb/tb_prbs_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Serial checker for the 16-bit XNOR LFSR stream (taps 16,15,13,4): seeds from the
// line, verifies, then free-runs a local reference and counts bit errors while locked.
module prbs_checker #(
   parameter int WIDTH       = 16,
   parameter int VERIFY_LEN  = 32,
   parameter int LOCK_WIN    = 64,
   parameter int LOSS_THRESH = 8,
   parameter int ERR_W       = 16,
   parameter int BIT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             locked,
   output logic             err_flag,
   output logic             lock_lost,
   output logic [ERR_W-1:0] err_count,
   output logic [BIT_W-1:0] bit_count,
   output logic [1:0]       state
);

   localparam int FILL_W  = $clog2(WIDTH + 1);
   localparam int MATCH_W = $clog2(VERIFY_LEN + 1);
   localparam int WIN_W   = $clog2(LOCK_WIN);
   localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

   typedef enum logic [1:0] {
      ST_SEED   = 2'b00,
      ST_VERIFY = 2'b01,
      ST_LOCKED = 2'b10
   } state_t;

   state_t               state_r;
   logic [WIDTH-1:0]     hist_r;
   logic [FILL_W-1:0]    fill_cnt_r;
   logic [MATCH_W-1:0]   match_cnt_r;
   logic [WIN_W-1:0]     win_cnt_r;
   logic [WERR_W-1:0]    win_err_r;

   logic                 pred_s;
   logic                 mismatch_s;
   logic [WIDTH-1:0]     seed_hist_s;
   logic [WERR_W-1:0]    win_err_next_s;
   logic                 loss_s;

   // Next bit of the XNOR sequence given the last WIDTH bits (oldest at the MSB).
   function automatic logic xnor_feedback(input logic [WIDTH-1:0] h);
      return ~(h[15] ^ h[14] ^ h[12] ^ h[3]);
   endfunction

   // Prediction, mismatch and window-threshold decode for the current bit.
   always_comb begin
      pred_s         = xnor_feedback(hist_r);
      mismatch_s     = bit_in ^ pred_s;
      seed_hist_s    = {hist_r[WIDTH-2:0], bit_in};
      win_err_next_s = win_err_r + WERR_W'(mismatch_s);
      if (mismatch_s && (win_err_next_s == WERR_W'(LOSS_THRESH))) begin
         loss_s = 1'b1;
      end else begin
         loss_s = 1'b0;
      end
   end

   assign state = state_r;

   // Sync FSM: seeding, verification and locked monitoring with registered flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_SEED;
         hist_r      <= '0;
         fill_cnt_r  <= '0;
         match_cnt_r <= '0;
         win_cnt_r   <= '0;
         win_err_r   <= '0;
         locked      <= 1'b0;
         err_flag    <= 1'b0;
         lock_lost   <= 1'b0;
      end else begin
         err_flag  <= 1'b0;
         lock_lost <= 1'b0;
         if (bit_valid) begin
            case (state_r)
               ST_SEED: begin
                  hist_r <= seed_hist_s;
                  if (fill_cnt_r == FILL_W'(WIDTH - 1)) begin
                     fill_cnt_r <= '0;
                     // All-ones is the XNOR lock-up state; it can never verify, so re-seed.
                     if (seed_hist_s != '1) begin
                        state_r     <= ST_VERIFY;
                        match_cnt_r <= '0;
                     end else begin
                        state_r <= ST_SEED;
                     end
                  end else begin
                     fill_cnt_r <= fill_cnt_r + FILL_W'(1);
                  end
               end
               ST_VERIFY: begin
                  hist_r <= seed_hist_s;
                  if (mismatch_s) begin
                     state_r     <= ST_SEED;
                     fill_cnt_r  <= '0;
                     match_cnt_r <= '0;
                  end else if (match_cnt_r == MATCH_W'(VERIFY_LEN - 1)) begin
                     state_r     <= ST_LOCKED;
                     locked      <= 1'b1;
                     match_cnt_r <= '0;
                     win_cnt_r   <= '0;
                     win_err_r   <= '0;
                  end else begin
                     match_cnt_r <= match_cnt_r + MATCH_W'(1);
                  end
               end
               ST_LOCKED: begin
                  // Reference free-runs on its own prediction so a bad bit costs one error.
                  hist_r   <= {hist_r[WIDTH-2:0], pred_s};
                  err_flag <= mismatch_s;
                  if (loss_s) begin
                     state_r    <= ST_SEED;
                     locked     <= 1'b0;
                     lock_lost  <= 1'b1;
                     fill_cnt_r <= '0;
                     win_cnt_r  <= '0;
                     win_err_r  <= '0;
                  end else if (win_cnt_r == WIN_W'(LOCK_WIN - 1)) begin
                     win_cnt_r <= '0;
                     win_err_r <= '0;
                  end else begin
                     win_cnt_r <= win_cnt_r + WIN_W'(1);
                     win_err_r <= win_err_next_s;
                  end
               end
               default: begin
                  state_r    <= ST_SEED;
                  locked     <= 1'b0;
                  fill_cnt_r <= '0;
               end
            endcase
         end else begin
            hist_r <= hist_r;
         end
      end
   end

   // Saturating bit and error totals; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_count <= '0;
         bit_count <= '0;
      end else if (clear) begin
         err_count <= '0;
         bit_count <= '0;
      end else if (bit_valid && (state_r == ST_LOCKED)) begin
         if (bit_count != '1) begin
            bit_count <= bit_count + BIT_W'(1);
         end else begin
            bit_count <= bit_count;
         end
         if (mismatch_s && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
         end else begin
            err_count <= err_count;
         end
      end else begin
         err_count <= err_count;
         bit_count <= bit_count;
      end
   end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a local XNOR LFSR generator drives the line and
// each scenario task compares outputs against hand-derived values.
module tb_prbs_checker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        bit_in = 1'b0;
   logic        bit_valid = 1'b0;
   logic        locked;
   logic        err_flag;
   logic        lock_lost;
   logic [15:0] err_count;
   logic [31:0] bit_count;
   logic [1:0]  state;

   logic [15:0] gen_r;
   logic        err_seen;
   logic        lost_seen;
   int          total = 0;
   int          bad = 0;

   prbs_checker dut (
      .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
      .locked(locked), .err_flag(err_flag), .lock_lost(lock_lost),
      .err_count(err_count), .bit_count(bit_count), .state(state)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic b, input logic v, input logic clr);
      @(negedge clk);
      bit_in = b; bit_valid = v; clear = clr;
      @(posedge clk);
      #1;
      if (err_flag) err_seen = 1'b1;
      if (lock_lost) lost_seen = 1'b1;
   endtask

   // Send n generator bits, optionally inverted, optionally with clear held.
   task automatic send(input int n, input logic inv, input logic clr);
      logic b;
      for (int i = 0; i < n; i++) begin
         b = gen_r[15];
         gen_r = {gen_r[14:0], ~(gen_r[15] ^ gen_r[14] ^ gen_r[12] ^ gen_r[3])};
         drive(b ^ inv, 1'b1, clr);
      end
   endtask

   task automatic send_gapped(input int n);
      for (int i = 0; i < n; i++) begin
         send(1, 1'b0, 1'b0);
         drive(i[0], 1'b0, 1'b0);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1; bit_valid = 1'b0; clear = 1'b0; bit_in = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      gen_r = 16'h00FC;
      err_seen = 1'b0;
      lost_seen = 1'b0;
   endtask

   task automatic do_lock();
      apply_reset();
      send(48, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      total++; if (state !== 2'b00) begin bad++; $display("FAIL rst_state: got=%b want=00", state); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got=%b want=0", locked); end
      total++; if (err_flag !== 1'b0 || lock_lost !== 1'b0) begin bad++; $display("FAIL rst_pulses: got=%b%b want=00", err_flag, lock_lost); end
      total++; if (err_count !== 16'd0 || bit_count !== 32'd0) begin bad++; $display("FAIL rst_counts: got=%0d/%0d want=0/0", err_count, bit_count); end
      reset = 1'b0;
   endtask

   task automatic test_lock();
      apply_reset();
      send(15, 1'b0, 1'b0);
      total++; if (state !== 2'b00) begin bad++; $display("FAIL lock_seed15: got=%b want=00", state); end
      send(1, 1'b0, 1'b0);
      total++; if (state !== 2'b01) begin bad++; $display("FAIL lock_verify16: got=%b want=01", state); end
      send(31, 1'b0, 1'b0);
      total++; if (locked !== 1'b0 || state !== 2'b01) begin bad++; $display("FAIL lock_bit47: got=%b/%b want=0/01", locked, state); end
      send(1, 1'b0, 1'b0);
      total++; if (locked !== 1'b1 || state !== 2'b10) begin bad++; $display("FAIL lock_bit48: got=%b/%b want=1/10", locked, state); end
      total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL lock_bc0: got=%0d want=0", bit_count); end
      send(65536, 1'b0, 1'b0);
      total++; if (err_seen !== 1'b0 || err_count !== 16'd0) begin bad++; $display("FAIL long_errs: got=%b/%0d want=0/0", err_seen, err_count); end
      total++; if (bit_count !== 32'd65536) begin bad++; $display("FAIL long_bits: got=%0d want=65536", bit_count); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL long_locked: got=%b want=1", locked); end
   endtask

   task automatic test_single_error();
      send(1, 1'b0, 1'b1);
      total++; if (err_count !== 16'd0 || bit_count !== 32'd0) begin bad++; $display("FAIL clr_counts: got=%0d/%0d want=0/0", err_count, bit_count); end
      send(10, 1'b0, 1'b0);
      send(1, 1'b1, 1'b0);
      total++; if (err_flag !== 1'b1 || err_count !== 16'd1) begin bad++; $display("FAIL single_err: got=%b/%0d want=1/1", err_flag, err_count); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL single_locked: got=%b want=1", locked); end
      send(1, 1'b0, 1'b0);
      total++; if (err_flag !== 1'b0) begin bad++; $display("FAIL single_pulse: got=%b want=0", err_flag); end
      err_seen = 1'b0;
      send(100, 1'b0, 1'b0);
      total++; if (err_seen !== 1'b0 || err_count !== 16'd1) begin bad++; $display("FAIL single_after: got=%b/%0d want=0/1", err_seen, err_count); end
      total++; if (bit_count !== 32'd112) begin bad++; $display("FAIL single_bits: got=%0d want=112", bit_count); end
   endtask

   task automatic test_loss();
      do_lock();
      send(7, 1'b1, 1'b0);
      total++; if (locked !== 1'b1 || lost_seen !== 1'b0) begin bad++; $display("FAIL loss_7: got=%b/%b want=1/0", locked, lost_seen); end
      send(1, 1'b1, 1'b0);
      total++; if (lock_lost !== 1'b1 || locked !== 1'b0 || state !== 2'b00) begin bad++; $display("FAIL loss_8: got=%b/%b/%b want=1/0/00", lock_lost, locked, state); end
      total++; if (err_count !== 16'd8) begin bad++; $display("FAIL loss_cnt: got=%0d want=8", err_count); end
      send(47, 1'b0, 1'b0);
      total++; if (locked !== 1'b0 || lock_lost !== 1'b0) begin bad++; $display("FAIL relock_47: got=%b/%b want=0/0", locked, lock_lost); end
      send(1, 1'b0, 1'b0);
      total++; if (locked !== 1'b1 || err_count !== 16'd8) begin bad++; $display("FAIL relock_48: got=%b/%0d want=1/8", locked, err_count); end
      lost_seen = 1'b0;
      send(57, 1'b0, 1'b0);
      send(7, 1'b1, 1'b0);
      send(1, 1'b1, 1'b0);
      total++; if (locked !== 1'b1 || lost_seen !== 1'b0 || err_count !== 16'd16) begin bad++; $display("FAIL win_split: got=%b/%b/%0d want=1/0/16", locked, lost_seen, err_count); end
      send(56, 1'b0, 1'b0);
      send(6, 1'b1, 1'b0);
      total++; if (locked !== 1'b1 || lost_seen !== 1'b0) begin bad++; $display("FAIL win_pre_last: got=%b/%b want=1/0", locked, lost_seen); end
      send(1, 1'b1, 1'b0);
      total++; if (lock_lost !== 1'b1 || state !== 2'b00 || err_count !== 16'd23) begin bad++; $display("FAIL win_last: got=%b/%b/%0d want=1/00/23", lock_lost, state, err_count); end
   endtask

   task automatic test_lockup_and_verify_fail();
      apply_reset();
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0);
      total++; if (state !== 2'b00) begin bad++; $display("FAIL lockup_16: got=%b want=00", state); end
      for (int i = 0; i < 60; i++) drive(1'b1, 1'b1, 1'b0);
      total++; if (state !== 2'b00 || locked !== 1'b0) begin bad++; $display("FAIL lockup_76: got=%b/%b want=00/0", state, locked); end
      apply_reset();
      send(35, 1'b0, 1'b0);
      total++; if (state !== 2'b01) begin bad++; $display("FAIL vfail_pre: got=%b want=01", state); end
      send(1, 1'b1, 1'b0);
      total++; if (state !== 2'b00) begin bad++; $display("FAIL vfail_seed: got=%b want=00", state); end
      send(47, 1'b0, 1'b0);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL vfail_47: got=%b want=0", locked); end
      send(1, 1'b0, 1'b0);
      total++; if (locked !== 1'b1 || err_count !== 16'd0) begin bad++; $display("FAIL vfail_48: got=%b/%0d want=1/0", locked, err_count); end
   endtask

   task automatic test_valid_gaps();
      apply_reset();
      send_gapped(16);
      total++; if (state !== 2'b01) begin bad++; $display("FAIL gap_verify: got=%b want=01", state); end
      send_gapped(31);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL gap_47: got=%b want=0", locked); end
      send_gapped(1);
      total++; if (locked !== 1'b1 || bit_count !== 32'd0) begin bad++; $display("FAIL gap_48: got=%b/%0d want=1/0", locked, bit_count); end
      send_gapped(50);
      send(1, 1'b1, 1'b0);
      total++; if (err_flag !== 1'b1 || err_count !== 16'd1 || bit_count !== 32'd51) begin bad++; $display("FAIL gap_err: got=%b/%0d/%0d want=1/1/51", err_flag, err_count, bit_count); end
      drive(1'b0, 1'b0, 1'b0);
      total++; if (err_flag !== 1'b0 || err_count !== 16'd1 || bit_count !== 32'd51) begin bad++; $display("FAIL gap_idle: got=%b/%0d/%0d want=0/1/51", err_flag, err_count, bit_count); end
      send_gapped(49);
      total++; if (bit_count !== 32'd100 || err_count !== 16'd1 || locked !== 1'b1) begin bad++; $display("FAIL gap_end: got=%0d/%0d/%b want=100/1/1", bit_count, err_count, locked); end
   endtask

   task automatic test_clear_reset();
      do_lock();
      send(5, 1'b0, 1'b0);
      send(1, 1'b1, 1'b1);
      total++; if (err_count !== 16'd0 || bit_count !== 32'd0) begin bad++; $display("FAIL clr_err: got=%0d/%0d want=0/0", err_count, bit_count); end
      total++; if (locked !== 1'b1 || err_flag !== 1'b1) begin bad++; $display("FAIL clr_state: got=%b/%b want=1/1", locked, err_flag); end
      send(1, 1'b0, 1'b0);
      total++; if (bit_count !== 32'd1 || err_count !== 16'd0) begin bad++; $display("FAIL clr_after: got=%0d/%0d want=1/0", bit_count, err_count); end
      @(negedge clk);
      bit_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      total++; if (locked !== 1'b0 || state !== 2'b00 || bit_count !== 32'd0 || err_flag !== 1'b0) begin bad++; $display("FAIL async_rst: got=%b/%b/%0d/%b want=0/00/0/0", locked, state, bit_count, err_flag); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      gen_r = 16'h00FC;
      err_seen = 1'b0;
      lost_seen = 1'b0;
      test_reset();
      test_lock();
      test_single_error();
      test_loss();
      test_lockup_and_verify_fail();
      test_valid_gaps();
      test_clear_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
